// File: rtl/reg_file_sb.sv
// Decode-stage register file: two combinational read ports, one write port,
// hardwired-zero x0, optional writeback bypass and a pending-write scoreboard.
module reg_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] a3,
    input  logic [DATA_WIDTH-1:0] wd3,
    input  logic [ADDR_WIDTH-1:0] a1,
    input  logic [ADDR_WIDTH-1:0] a2,
    output logic [DATA_WIDTH-1:0] rd1,
    output logic [DATA_WIDTH-1:0] rd2,
    input  logic                  issue_enable,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    output logic                  busy1,
    output logic                  busy2,
    output logic [ADDR_WIDTH:0]   busy_count
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] reg_array_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] reg_array_d [NUM_REGS];
    logic [NUM_REGS-1:0]   pending_q;
    logic [NUM_REGS-1:0]   pending_d;
    logic [ADDR_WIDTH:0]   busy_count_q;
    logic [ADDR_WIDTH:0]   busy_count_d;

    always_comb begin
        reg_array_d = reg_array_q;
        if (write_enable && (a3 != '0)) begin
            reg_array_d[a3] = wd3;
        end
        reg_array_d[0] = '0;
    end

    // A new producer issuing to r outranks a writeback that retires r's old producer.
    always_comb begin
        pending_d    = pending_q;
        busy_count_d = '0;
        pending_d[0] = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (issue_enable && (issue_rd == ADDR_WIDTH'(r))) begin
                pending_d[r] = 1'b1;
            end else if (write_enable && (a3 == ADDR_WIDTH'(r))) begin
                pending_d[r] = 1'b0;
            end
            busy_count_d = busy_count_d + (ADDR_WIDTH + 1)'(pending_d[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_array_q  <= '{default: '0};
            pending_q    <= '0;
            busy_count_q <= '0;
        end else begin
            reg_array_q  <= reg_array_d;
            pending_q    <= pending_d;
            busy_count_q <= busy_count_d;
        end
    end

    always_comb begin
        rd1   = '0;
        busy1 = 1'b0;
        if (a1 != '0) begin
            if ((BYPASS != 0) && write_enable && (a3 == a1)) begin
                rd1 = wd3;
            end else begin
                rd1   = reg_array_q[a1];
                busy1 = pending_q[a1];
            end
        end
    end

    always_comb begin
        rd2   = '0;
        busy2 = 1'b0;
        if (a2 != '0) begin
            if ((BYPASS != 0) && write_enable && (a3 == a2)) begin
                rd2 = wd3;
            end else begin
                rd2   = reg_array_q[a2];
                busy2 = pending_q[a2];
            end
        end
    end

    assign busy_count = busy_count_q;

endmodule
